// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: funct3 encodings, LSU state encoding
// and the accept-time access legality check.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'b00,
    LSU_READ  = 2'b01,
    LSU_WRITE = 2'b10,
    LSU_DONE  = 2'b11
  } lsu_state_e;

  // Unsigned variants only exist for loads; anything else outside the table is illegal.
  function automatic logic lsu_access_error(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] lane);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = lane[0];
      F3_W:    err = (lane != 2'b00);
      F3_BU:   err = is_store;
      F3_HU:   err = is_store | lane[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: merges sub-word store data into a memory word and
// extracts/extends sub-word load values. Purely combinational.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] store_word,
  output logic [31:0] load_value
);

  logic [4:0]  byte_sel;
  logic [4:0]  half_sel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sel = {lane, 3'b000};
  assign half_sel = {lane[1], 4'b0000};
  assign byte_v   = mem_word[byte_sel +: 8];
  assign half_v   = mem_word[half_sel +: 16];

  // Store merge: untouched lanes keep the word read from memory.
  always_comb begin
    store_word = mem_word;
    case (funct3)
      F3_B:    store_word[byte_sel +: 8]  = store_data[7:0];
      F3_H:    store_word[half_sel +: 16] = store_data[15:0];
      F3_W:    store_word = store_data;
      default: store_word = mem_word;
    endcase
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    load_value = 32'h0000_0000;
    case (funct3)
      F3_B:    load_value = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_value = {24'h00_0000, byte_v};
      F3_H:    load_value = {{16{half_v[15]}}, half_v};
      F3_HU:   load_value = {16'h0000, half_v};
      F3_W:    load_value = mem_word;
      default: load_value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a word-only memory,
// with read-modify-write for sub-word stores and misalignment/illegal checks.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ready,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              done,
  output logic              error,
  output logic [31:0]       load_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [31:0]       store_data_q, store_data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              error_q, error_d;

  logic              accept_err;
  logic [31:0]       align_word;
  logic [31:0]       merged_word;
  logic [31:0]       load_value;

  assign accept_err = lsu_access_error(is_store, funct3, addr[1:0]);
  // Loads extract straight from the bus at the closing READ edge; merges use the latched word.
  assign align_word = (state_q == LSU_READ) ? mem_read_data : rdata_q;

  lsu_lane_align u_align (
    .funct3     (funct3_q),
    .lane       (addr_q[1:0]),
    .mem_word   (align_word),
    .store_data (store_data_q),
    .store_word (merged_word),
    .load_value (load_value)
  );

  // Next-state and register update logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    is_store_d   = is_store_q;
    store_data_d = store_data_q;
    rdata_d      = rdata_q;
    load_data_d  = load_data_q;
    error_d      = error_q;
    case (state_q)
      LSU_IDLE: begin
        if (req) begin
          addr_d       = addr;
          funct3_d     = funct3;
          is_store_d   = is_store;
          store_data_d = store_data;
          error_d      = accept_err;
          if (accept_err) begin
            state_d = LSU_DONE;
          end else if (is_store && (funct3 == F3_W)) begin
            state_d = LSU_WRITE;
          end else begin
            state_d = LSU_READ;
          end
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_READ: begin
        rdata_d = mem_read_data;
        if (is_store_q) begin
          state_d = LSU_WRITE;
        end else begin
          state_d     = LSU_DONE;
          load_data_d = load_value;
        end
      end
      LSU_WRITE: state_d = LSU_DONE;
      LSU_DONE:  state_d = LSU_IDLE;
      default:   state_d = LSU_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LSU_IDLE;
      addr_q       <= '0;
      funct3_q     <= 3'b000;
      is_store_q   <= 1'b0;
      store_data_q <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      load_data_q  <= 32'h0000_0000;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      is_store_q   <= is_store_d;
      store_data_q <= store_data_d;
      rdata_q      <= rdata_d;
      load_data_q  <= load_data_d;
      error_q      <= error_d;
    end
  end

  assign ready          = (state_q == LSU_IDLE);
  assign done           = (state_q == LSU_DONE);
  assign error          = (state_q == LSU_DONE) & error_q;
  assign load_data      = load_data_q;
  assign mem_read       = (state_q == LSU_READ);
  assign mem_write      = (state_q == LSU_WRITE);
  assign mem_address    = (state_q == LSU_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_write_data = (state_q == LSU_WRITE) ? merged_word : 32'h0000_0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a small word memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req;
  logic        ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        done;
  logic        error;
  logic [31:0] load_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  typedef struct {
    logic        err;
    logic [31:0] ld;
    int          lat;
    int          n_rd;
    int          n_wr;
    logic [31:0] wdata;
    logic [31:0] waddr;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_bad;
  int          cyc;
  logic [31:0] mem [64];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .ready          (ready),
    .is_store       (is_store),
    .funct3         (funct3),
    .addr           (addr),
    .store_data     (store_data),
    .done           (done),
    .error          (error),
    .load_data      (load_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_read_data = mem[mem_address[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[4] = 32'h8899_AABB;
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts memory cycles per transaction and checks each done against the scoreboard.
  initial begin
    int          rd_n;
    int          wr_n;
    logic        ovl;
    logic [31:0] wd;
    logic [31:0] wa;
    exp_t        e;
    rd_n = 0; wr_n = 0; ovl = 1'b0; wd = 32'h0; wa = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_n = 0; wr_n = 0; ovl = 1'b0;
      end else begin
        if (mem_read && mem_write) ovl = 1'b1;
        if (mem_read) rd_n++;
        if (mem_write) begin
          wr_n++;
          wd = mem_write_data;
          wa = mem_address;
        end
        if (done) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
          end else begin
            e = sb_q.pop_front();
            chk("error",         {31'b0, error}, {31'b0, e.err});
            chk("load_data",     load_data, e.ld);
            chk("latency",       cyc - e.acc, e.lat);
            chk("read_cycles",   rd_n, e.n_rd);
            chk("write_cycles",  wr_n, e.n_wr);
            chk("rd_wr_overlap", {31'b0, ovl}, 32'h0);
            if (e.n_wr > 0) begin
              chk("write_data", wd, e.wdata);
              chk("write_addr", wa, e.waddr);
            end
          end
          rd_n = 0; wr_n = 0; ovl = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic err, input logic [31:0] ld,
                       input int lat, input int nrd, input int nwr,
                       input logic [31:0] wd, input bit hold);
    exp_t e;
    bit   got;
    @(negedge clk);
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    req        = 1'b1;
    e.err = err; e.ld = ld; e.lat = lat; e.n_rd = nrd; e.n_wr = nwr;
    e.wdata = wd; e.waddr = {a[31:2], 2'b00}; e.acc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    req = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles (addr %h)", a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    req = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready",     {31'b0, ready}, 32'h1);
    chk("rst_done",      {31'b0, done}, 32'h0);
    chk("rst_error",     {31'b0, error}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_mem_read",  {31'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_mem_addr",  mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    reset = 1'b0;

    // st, f3, addr, sdata, err, load_data, lat, rd, wr, wdata, hold
    issue(1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFF_FF88, 2, 1, 0, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h12, 32'h0,        1'b0, 32'h0000_0099, 2, 1, 0, 32'h0, 1'b0);
    issue(1'b0, 3'b101, 32'h10, 32'h0,        1'b0, 32'h0000_AABB, 2, 1, 0, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFF_8899, 2, 1, 0, 32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'h11, 32'h1234_56CC, 1'b0, 32'hFFFF_8899, 3, 1, 1, 32'h8899_CCBB, 1'b0);
    issue(1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h8899_CCBB, 2, 1, 0, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h8899_CCBB, 2, 0, 1, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'hDEAD_BEEF, 2, 1, 0, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'h11, 32'h0,        1'b1, 32'hDEAD_BEEF, 1, 0, 0, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h22, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF, 1, 0, 0, 32'h0, 1'b0);
    issue(1'b1, 3'b100, 32'h20, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF, 1, 0, 0, 32'h0, 1'b0);
    issue(1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'hDEAD_BEEF, 1, 0, 0, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'h12, 32'h0000_BEAD, 1'b0, 32'hDEAD_BEEF, 3, 1, 1, 32'hBEAD_CCBB, 1'b0);
    issue(1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hBEAD_CCBB, 2, 1, 0, 32'h0, 1'b0);
    issue(1'b0, 3'b000, 32'h12, 32'h0,        1'b0, 32'hFFFF_FFAD, 2, 1, 0, 32'h0, 1'b0);

    // Abort SW 0x30 in its WRITE cycle; the word must not be committed.
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'b010; addr = 32'h30; store_data = 32'hFFFF_FFFF;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("pre_abort_mem_write", {31'b0, mem_write}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_mem_write", {31'b0, mem_write}, 32'h0);
    chk("abort_ready",     {31'b0, ready}, 32'h1);
    chk("abort_done",      {31'b0, done}, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'h0000_0000, 2, 1, 0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
